// File: rtl/scr_stack_ctrl_pkg.sv
// Shared widths and enumerations for the RAT MCU scratch-RAM front end.
package scr_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        ADDR_DY   = 2'b00,
        ADDR_IMM  = 2'b01,
        ADDR_SP   = 2'b10,
        ADDR_SPM1 = 2'b11
    } scr_addr_sel_t;

    typedef enum logic {
        DATA_DX = 1'b0,
        DATA_PC = 1'b1
    } scr_data_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        DONE  = 2'b10
    } clr_state_t;
endpackage

// File: rtl/scr_stack_ctrl_if.sv
// Control-unit <-> scratch front-end bundle; master is the control unit side.
interface scr_stack_ctrl_if #(
    parameter int ADDR_W = scr_pkg::ADDR_W,
    parameter int DATA_W = scr_pkg::DATA_W
);
    logic              SP_LD;
    logic              SP_INCR;
    logic              SP_DECR;
    logic [1:0]        SCR_ADDR_SEL;
    logic              SCR_DATA_SEL;
    logic              SCR_WE_REQ;
    logic [7:0]        DX_OUT;
    logic [7:0]        DY_OUT;
    logic [7:0]        IR_IMM;
    logic [DATA_W-1:0] PC_COUNT;
    logic              CLR_START;
    logic [7:0]        SP_OUT;
    logic [ADDR_W-1:0] SCR_ADDR;
    logic [DATA_W-1:0] SCR_DATA_IN;
    logic              SCR_WE;
    logic              BUSY;
    logic              CLR_DONE;
    logic              STK_ERR;

    modport master (
        output SP_LD, SP_INCR, SP_DECR, SCR_ADDR_SEL, SCR_DATA_SEL, SCR_WE_REQ,
               DX_OUT, DY_OUT, IR_IMM, PC_COUNT, CLR_START,
        input  SP_OUT, SCR_ADDR, SCR_DATA_IN, SCR_WE, BUSY, CLR_DONE, STK_ERR
    );

    modport slave (
        input  SP_LD, SP_INCR, SP_DECR, SCR_ADDR_SEL, SCR_DATA_SEL, SCR_WE_REQ,
               DX_OUT, DY_OUT, IR_IMM, PC_COUNT, CLR_START,
        output SP_OUT, SCR_ADDR, SCR_DATA_IN, SCR_WE, BUSY, CLR_DONE, STK_ERR
    );
endinterface

// File: rtl/scr_stack_ctrl_stack_ptr.sv
// Stack pointer with a 0..256 occupancy counter and a sticky over/underflow flag.
module stack_ptr #(
    parameter logic [7:0] SP_RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ld,
    input  logic       incr,
    input  logic       decr,
    input  logic [7:0] din,
    output logic [7:0] sp,
    output logic       stk_err
);
    import scr_pkg::*;

    localparam logic [8:0] DEPTH_MAX = 9'd256;

    logic [8:0] depth_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp      <= SP_RST;
            depth_q <= '0;
            stk_err <= 1'b0;
        end else if (en) begin
            if (ld) begin
                sp      <= din;
                depth_q <= '0;
                stk_err <= 1'b0;
            end else if (decr && !incr) begin
                // SP always wraps; only the occupancy count saturates
                sp <= sp - 8'd1;
                if (depth_q == DEPTH_MAX) stk_err <= 1'b1;
                else                      depth_q <= depth_q + 9'd1;
            end else if (incr && !decr) begin
                sp <= sp + 8'd1;
                if (depth_q == 9'd0) stk_err <= 1'b1;
                else                 depth_q <= depth_q - 9'd1;
            end
        end
    end
endmodule

// File: rtl/scr_stack_ctrl.sv
// Scratch-RAM front end: address/data muxing, stack pointer and zero-fill engine.
module scr_stack_ctrl #(
    parameter int         ADDR_W = scr_pkg::ADDR_W,
    parameter int         DATA_W = scr_pkg::DATA_W,
    parameter logic [7:0] SP_RST = 8'h00
) (
    input logic             clk,
    input logic             RST,
    scr_stack_ctrl_if.slave bus
);
    import scr_pkg::*;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [7:0]        sp;
    logic [ADDR_W-1:0] addr_mux;

    stack_ptr #(.SP_RST(SP_RST)) u_stack_ptr (
        .clk     (clk),
        .rst     (RST),
        .en      (state_q != CLEAR),
        .ld      (bus.SP_LD),
        .incr    (bus.SP_INCR),
        .decr    (bus.SP_DECR),
        .din     (bus.DX_OUT),
        .sp      (sp),
        .stk_err (bus.STK_ERR)
    );

    assign bus.SP_OUT = sp;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.CLR_START) state_d = CLEAR;
            CLEAR:   if (&cnt_q)        state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_mux = '0;
        case (scr_addr_sel_t'(bus.SCR_ADDR_SEL))
            ADDR_DY:   addr_mux = ADDR_W'(bus.DY_OUT);
            ADDR_IMM:  addr_mux = ADDR_W'(bus.IR_IMM);
            ADDR_SP:   addr_mux = ADDR_W'(sp);
            ADDR_SPM1: addr_mux = ADDR_W'(sp - 8'd1);
            default:   addr_mux = '0;
        endcase
    end

    // Clear engine owns the RAM port while active; otherwise the request mux drives it
    always_comb begin
        bus.SCR_ADDR    = addr_mux;
        bus.SCR_DATA_IN = (scr_data_sel_t'(bus.SCR_DATA_SEL) == DATA_PC) ?
                          bus.PC_COUNT : DATA_W'(bus.DX_OUT);
        bus.SCR_WE      = bus.SCR_WE_REQ & ~RST;
        bus.BUSY        = 1'b0;
        bus.CLR_DONE    = 1'b0;
        case (state_q)
            CLEAR: begin
                bus.SCR_ADDR    = cnt_q;
                bus.SCR_DATA_IN = '0;
                bus.SCR_WE      = 1'b1;
                bus.BUSY        = 1'b1;
            end
            DONE:    bus.CLR_DONE = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/scr_stack_ctrl.md
Name: scr_stack_ctrl

Overview:
Scratch-RAM front end for the RAT MCU. It sits directly upstream of the scratch RAM and drives its SCR_ADDR, DATA_IN and SCR_WE inputs. It owns the stack pointer (SP) and multiplexes address and data sources for register, immediate, PUSH/POP and CALL/RET accesses. It also contains a hardware clear engine that zero-fills all 256 locations on command.

Parameters:
ADDR_W, 8, scratch address width; depth = 2**ADDR_W
DATA_W, 10, scratch data width; must be at least 8 and match PC width
SP_RST, 8'h00, SP value after reset

Ports:
clk  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
SP_LD  in  1  load SP from DX_OUT
SP_INCR  in  1  SP <= SP+1 (pop/ret)
SP_DECR  in  1  SP <= SP-1 (push/call)
SCR_ADDR_SEL  in  2  00 DY_OUT, 01 IR_IMM, 10 SP, 11 SP-1
SCR_DATA_SEL  in  1  0 DX_OUT zero-extended, 1 PC_COUNT
SCR_WE_REQ  in  1  write request from control unit
DX_OUT  in  8  register file port X
DY_OUT  in  8  register file port Y
IR_IMM  in  8  instruction immediate field
PC_COUNT  in  DATA_W  program counter, for CALL
CLR_START  in  1  start zero-fill
SP_OUT  out  8  current SP
SCR_ADDR  out  ADDR_W  to scratch RAM
SCR_DATA_IN  out  DATA_W  to scratch RAM
SCR_WE  out  1  to scratch RAM
BUSY  out  1  clear engine active
CLR_DONE  out  1  one-cycle pulse when clear completes
STK_ERR  out  1  sticky stack overflow/underflow flag

Behaviour:
- Reset values (async on RST=1): SP=SP_RST, depth=0, STK_ERR=0, FSM=IDLE, clear counter=0, BUSY=0, CLR_DONE=0.
  - SCR_WE=0 during reset.
  - SCR_ADDR and SCR_DATA_IN follow the IDLE mux with SP=SP_RST.
- SP update priority, one per cycle: SP_LD > (SP_INCR xor SP_DECR).
  - INCR and DECR both high: SP holds, depth holds, no error.
  - Arithmetic is modulo 256: 0x00-1 = 0xFF, 0xFF+1 = 0x00.
  - The new SP is visible on SP_OUT the next cycle.
- Depth counter (9 bits, 0..256):
  - DECR increments depth; INCR decrements it.
  - SP_LD sets depth to 0 and clears STK_ERR.
  - DECR with depth=256 sets STK_ERR. SP still wraps; depth saturates at 256.
  - INCR with depth=0 sets STK_ERR. SP still wraps; depth stays 0.
  - STK_ERR clears only on RST or SP_LD.
- IDLE mux (combinational, zero latency):
  - SCR_ADDR selects per SCR_ADDR_SEL; SP-1 is computed modulo 256.
  - SCR_DATA_IN selects per SCR_DATA_SEL.
  - SCR_WE = SCR_WE_REQ.
  - PUSH convention: write at SP-1 with SP_DECR in the same cycle.
  - POP convention: read at SP with SP_INCR in the same cycle. Read data is valid in the current cycle because the RAM read is asynchronous.
- FSM states:
  - IDLE: CLR_START=1 -> CLEAR next edge, counter=0. SP ops and the write request issued in that same cycle still take effect.
  - CLEAR: SCR_ADDR=counter, SCR_DATA_IN=0, SCR_WE=1, BUSY=1. Counter increments each cycle. After writing address 255, go to DONE (256 write cycles total).
  - CLEAR, inputs: SCR_WE_REQ, SP_LD, SP_INCR, SP_DECR and CLR_START are ignored. SP, depth and STK_ERR hold.
  - DONE: one cycle with CLR_DONE=1, BUSY=0, IDLE mux active and requests honoured, then IDLE.
- RST asserted mid-clear: immediate return to IDLE with SCR_WE=0. Locations already written stay zero; no resume.

Decomposition:
- Package scr_pkg holds:
  - widths: ADDR_W, DATA_W
  - enums: scr_addr_sel_t {ADDR_DY, ADDR_IMM, ADDR_SP, ADDR_SPM1}, scr_data_sel_t {DATA_DX, DATA_PC}, clr_state_t {IDLE, CLEAR, DONE}
- Sub-module stack_ptr: SP register, depth counter and STK_ERR. Its inputs are LD, INCR, DECR, DIN and an enable (deasserted while BUSY). Its outputs are SP and STK_ERR.

Test Plan:
- Reset: RST=1 asynchronously mid-cycle -> SP_OUT=0x00, STK_ERR=0, BUSY=0, SCR_WE=0.
- PUSH/POP: SP=0x00, DX_OUT=0x2A, SEL=11, WE_REQ=1, DECR=1 -> SCR_ADDR=0xFF, SCR_DATA_IN=0x02A, SCR_WE=1; next cycle SP_OUT=0xFF. Then SEL=10, INCR=1 -> SCR_ADDR=0xFF; next cycle SP_OUT=0x00, STK_ERR=0.
- CALL: SCR_DATA_SEL=1, PC_COUNT=0x3C5, SEL=11 -> SCR_DATA_IN=0x3C5.
- Stack errors:
  - Underflow: after SP_LD with DX_OUT=0x80, INCR -> SP_OUT=0x81, STK_ERR=1, stays 1 over 10 idle cycles; SP_LD clears it.
  - Overflow: 257 consecutive DECR after SP_LD -> STK_ERR=1 on the 257th.
- Clear:
  - Pulse CLR_START -> BUSY=1 for exactly 256 cycles with SCR_ADDR 0x00..0xFF ascending, SCR_DATA_IN=0, SCR_WE=1, then CLR_DONE=1 for one cycle.
  - DECR and WE_REQ asserted during CLEAR -> SP unchanged, no extra writes.
- Reset mid-clear: RST at counter=0x40 -> BUSY=0, SCR_WE=0 immediately. Addresses 0x00..0x3F read zero; 0x40 and above keep their prior contents.
